// File: rtl/ind_mem_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// lc3b_types
//   Types shared by the MEM-stage indirect-access sequencer.
//   lc3b_word   : one machine word (address or data)
//   ind_state_t : sequencer phase
//                 IDLE - pass-through
//                 PTR  - pointer read
//                 DATA - data read or write
//                 HOLD - holding the loaded word while MEM/WB is stalled
// ----------------------------------------------------------------------------
package lc3b_types;

    localparam int WORD_W = 16;

    typedef logic [WORD_W-1:0] lc3b_word;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PTR  = 2'd1,
        DATA = 2'd2,
        HOLD = 2'd3
    } ind_state_t;

endpackage

// File: rtl/ind_mem_sequencer_if.sv
// ----------------------------------------------------------------------------
// ind_mem_sequencer_if
//   Data-cache request/response bus between the MEM-stage sequencer and the
//   data cache.
//   dmem_address : word address of the access
//   dmem_read    : read request strobe, held until dmem_resp
//   dmem_write   : write request strobe, held until dmem_resp
//   dmem_wdata   : write data
//   dmem_wmask   : byte enables for a write
//   dmem_rdata   : read data, valid in the cycle dmem_resp is high
//   dmem_resp    : the cache completes the current access this cycle
// Modports: master = sequencer side, slave = cache side.
// ----------------------------------------------------------------------------
interface ind_mem_sequencer_if #(
    parameter int WIDTH = 16,
    parameter int MASKW = WIDTH / 8
);

    logic [WIDTH-1:0] dmem_address;
    logic             dmem_read;
    logic             dmem_write;
    logic [WIDTH-1:0] dmem_wdata;
    logic [MASKW-1:0] dmem_wmask;
    logic [WIDTH-1:0] dmem_rdata;
    logic             dmem_resp;

    modport master (
        output dmem_address, dmem_read, dmem_write, dmem_wdata, dmem_wmask,
        input  dmem_rdata, dmem_resp
    );

    modport slave (
        input  dmem_address, dmem_read, dmem_write, dmem_wdata, dmem_wmask,
        output dmem_rdata, dmem_resp
    );

endinterface

// File: rtl/ind_mem_sequencer.sv
// ----------------------------------------------------------------------------
// ind_mem_sequencer
//   MEM-stage sequencer for the data-memory port. Ordinary loads/stores pass
//   straight through to the cache. LDI/STI become two back-to-back accesses:
//   a pointer read at mem_addr, then a data read or write at the pointer word.
//
// Ports
//   clk, reset     : pipeline clock, asynchronous active-high reset
//   mem_valid      : MEM stage holds a live instruction
//   mem_is_ind     : instruction is LDI or STI
//   mem_is_store   : indirect op is STI
//   mem_read/write : ordinary load/store request
//   mem_addr       : effective address (pointer address for LDI/STI)
//   mem_wdata      : store data
//   mem_wmask      : byte mask for ordinary stores
//   pipe_stall     : MEM/WB register is stalled this cycle
//   flush          : squash of the MEM instruction
//   dmem           : cache bus (master side)
//   mem_rdata      : load result to MEM/WB
//   sti_ldi_sig    : pointer phase active, freezes the front of the pipe
//   ind_busy       : sequencer is not idle
// ----------------------------------------------------------------------------
module ind_mem_sequencer
    import lc3b_types::*;
#(
    parameter int WIDTH = 16,
    parameter int MASKW = WIDTH / 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     mem_valid,
    input  logic                     mem_is_ind,
    input  logic                     mem_is_store,
    input  logic                     mem_read,
    input  logic                     mem_write,
    input  logic [WIDTH-1:0]         mem_addr,
    input  logic [WIDTH-1:0]         mem_wdata,
    input  logic [MASKW-1:0]         mem_wmask,
    input  logic                     pipe_stall,
    input  logic                     flush,
    ind_mem_sequencer_if.master      dmem,
    output logic [WIDTH-1:0]         mem_rdata,
    output logic                     sti_ldi_sig,
    output logic                     ind_busy
);

    ind_state_t       state_q, state_d;
    logic [WIDTH-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             flush_q, flush_d;

    logic             rd_c, wr_c, sig_c;
    logic [WIDTH-1:0] addr_c;
    logic [MASKW-1:0] wmask_c;
    logic [WIDTH-1:0] mem_rdata_c;
    logic             flush_pend;

    // A flush seen this cycle counts the same as one remembered earlier.
    assign flush_pend = flush_q | flush;

    always_comb begin
        // NOTE: every signal gets a default first so no branch can leave a latch.
        state_d     = state_q;
        ptr_d       = ptr_q;
        rdata_d     = rdata_q;
        flush_d     = flush_q;
        rd_c        = 1'b0;
        wr_c        = 1'b0;
        sig_c       = 1'b0;
        addr_c      = mem_addr;
        wmask_c     = '0;
        mem_rdata_c = dmem.dmem_rdata;

        unique case (state_q)
            IDLE: begin
                if (mem_valid && mem_is_ind) begin
                    // Indirect ops issue nothing here; a flush squashes them.
                    if (!flush) state_d = PTR;
                end else begin
                    rd_c    = mem_read;
                    wr_c    = mem_write;
                    wmask_c = mem_wmask;
                end
            end

            PTR: begin
                rd_c    = 1'b1;
                sig_c   = 1'b1;
                flush_d = flush_pend;
                // The read stays asserted through a flush until the cache answers.
                if (dmem.dmem_resp) begin
                    ptr_d   = dmem.dmem_rdata;
                    state_d = flush_pend ? IDLE : DATA;
                end
            end

            DATA: begin
                addr_c  = ptr_q;
                flush_d = flush_pend;
                if (mem_is_store) begin
                    wr_c    = 1'b1;
                    wmask_c = '1;
                end else begin
                    rd_c = 1'b1;
                end
                if (dmem.dmem_resp) begin
                    rdata_d = dmem.dmem_rdata;
                    if (flush_pend || !pipe_stall) state_d = IDLE;
                    else                           state_d = HOLD;
                end
            end

            HOLD: begin
                mem_rdata_c = rdata_q;
                if (!pipe_stall) state_d = IDLE;
            end
        endcase

        if (state_d == IDLE) flush_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            rdata_q <= '0;
            flush_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values.
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rdata_q <= rdata_d;
            flush_q <= flush_d;
        end
    end

    // Strobes are gated by reset so they drop at once, even mid-access and
    // even while ordinary requests are presented during reset.
    assign dmem.dmem_read    = rd_c & ~reset;
    assign dmem.dmem_write   = wr_c & ~reset;
    assign dmem.dmem_address = addr_c;
    assign dmem.dmem_wdata   = mem_wdata;
    assign dmem.dmem_wmask   = wmask_c;
    assign mem_rdata         = mem_rdata_c;
    assign sti_ldi_sig       = sig_c & ~reset;
    assign ind_busy          = (state_q != IDLE);

endmodule
